bus_responder: RTL and testbench

- Memory-side target for the VeriRISC CPU bus. It answers the controller's rd/wr strobes on a 5-bit address / 8-bit data bus.
- Holds the program/data RAM and one memory-mapped output port.
- Contains a boot loader: it streams a program image in over a valid/ready byte interface while holding the CPU in reset, then releases the CPU.
- Sits beside the CPU core in the system top, in place of a bare single-port memory.

---
 rtl/bus_responder_pkg.sv | 20 ++
 rtl/bus_responder_counter.sv | 35 +++
 rtl/bus_responder.sv | 145 ++++++++++++++
 tb/tb_bus_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_responder_pkg
// Shared constants and types for the VeriRISC bus responder.
//   state_t      : 1-bit FSM encoding (ST_LOAD while booting, ST_RUN after).
//   DEF_AWIDTH   : default address width (RAM depth = 2**AWIDTH).
//   DEF_DWIDTH   : default data width.
//   DEF_IO_ADDR  : default address of the memory-mapped output port.
// -----------------------------------------------------------------------------
package bus_responder_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_AWIDTH  = 5;
  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_IO_ADDR = 31;

endpackage : bus_responder_pkg

// File: rtl/bus_responder_counter.sv
// -----------------------------------------------------------------------------
// bus_responder_counter
// Loadable up-counter used as the boot loader's write pointer.
// Ports:
//   clk    : clock, rising edge.
//   rst    : asynchronous active-high reset, clears count.
//   load   : synchronous load of data (has priority over enab).
//   enab   : count enable.
//   data   : value loaded when load=1.
//   count  : current count.
// -----------------------------------------------------------------------------
module bus_responder_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  // NOTE: clocked state is assigned with <= so every flop samples pre-edge
  // values; blocking '=' here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= data;
    end else if (enab) begin
      count <= count + 1'b1;
    end
  end

endmodule : bus_responder_counter

// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
// Memory-side target for the VeriRISC CPU bus: program/data RAM, one
// memory-mapped output port and a boot loader that streams a program image in
// over a valid/ready byte interface while holding the CPU in reset.
// Ports:
//   clk, rst          : clock / asynchronous active-high reset.
//   rd, wr            : CPU read / write strobes (ignored while loading).
//   addr, wdata       : CPU address and write data.
//   rdata, rdata_oe   : combinational read data and its bus drive enable.
//   ld_valid, ld_data : loader byte stream; ld_last marks the final byte.
//   ld_ready          : loader byte accepted (high only while loading).
//   cpu_rst           : registered reset to the CPU core, high until loaded.
//   io_out, io_strobe : output port register and its one-cycle write pulse.
//   bus_err           : sticky protocol-error flag (only when the macro
//                       RESP_ERR_CHECK_EN is defined).
// -----------------------------------------------------------------------------
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int IO_ADDR = DEF_IO_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_oe,
  input  logic              ld_valid,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic [DWIDTH-1:0] io_out,
  output logic              io_strobe
`ifdef RESP_ERR_CHECK_EN
  ,
  output logic              bus_err
`endif
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ld_ptr;
  logic              in_run, accept, ptr_full, io_hit;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  assign in_run   = (state_q == ST_RUN);
  // ld_ready is held low during rst so no byte is taken while reset is active.
  assign ld_ready = ~in_run & ~rst;
  assign accept   = ld_valid & ld_ready;
  assign ptr_full = &ld_ptr;
  assign io_hit   = (addr == AWIDTH'(IO_ADDR));

  // Pointer stops at the top entry: the full-RAM byte moves us to RUN, so the
  // pointer never wraps back over the image.
  bus_responder_counter #(.WIDTH(AWIDTH)) u_ld_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .enab  (accept & ~ptr_full),
    .data  ('0),
    .count (ld_ptr)
  );

  // NOTE: every signal written in always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (accept && (ld_last || ptr_full)) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cpu_rst <= 1'b1;
    end else begin
      state_q <= state_d;
      // Follows the registered state, so release lags entry to RUN by a cycle
      // and comes straight from a flop (glitch-free).
      cpu_rst <= ~in_run;
    end
  end

  // Single RAM write port shared by the loader and the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (!in_run) begin
      mem_we    = accept;
      mem_waddr = ld_ptr;
      mem_wdata = ld_data;
    end else begin
      mem_we    = wr;
    end
  end

  // NOTE: the RAM has no reset; clearing an array costs a mux per bit and
  // contents deliberately survive rst (mid-load reset keeps earlier bytes).
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Zero-latency read; suppressed on rd&wr so the bus is never double-driven.
  assign rdata    = mem[addr];
  assign rdata_oe = in_run & rd & ~wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else if (in_run && wr && io_hit) begin
      io_out    <= wdata;
      io_strobe <= 1'b1;
    end else begin
      io_strobe <= 1'b0;
    end
  end

`ifdef RESP_ERR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((in_run && rd && wr) || (!in_run && (rd || wr)) ||
                 (in_run && ld_valid)) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule : bus_responder

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
// Directed self-checking bench for bus_responder. Inputs change on the falling
// edge, outputs are sampled away from the rising edge.
// -----------------------------------------------------------------------------
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd, wr;
  logic [4:0] addr;
  logic [7:0] wdata, rdata, ld_data, io_out;
  logic       rdata_oe, ld_valid, ld_last, ld_ready, cpu_rst, io_strobe;
`ifdef RESP_ERR_CHECK_EN
  logic       bus_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_oe  (rdata_oe),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .io_out    (io_out),
    .io_strobe (io_strobe)
`ifdef RESP_ERR_CHECK_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Present one loader byte for exactly one rising edge.
  task automatic load_byte(input logic [7:0] data, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Combinational read, checked without any clock edge.
  task automatic read_chk(input string tag, input logic [4:0] a,
                          input logic [7:0] exp);
    @(negedge clk);
    rd   = 1'b1;
    addr = a;
    #1;
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".oe"}, rdata_oe, 1'b1);
    rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst.cpu_rst",   cpu_rst,   1'b1);
    check("rst.io_out",    io_out,    8'h00);
    check("rst.io_strobe", io_strobe, 1'b0);
    check("rst.rdata_oe",  rdata_oe,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ld_ready", ld_ready, 1'b1);
    rd = 1'b1; addr = 5'd3; #1;
    check("load.rd_ignored_oe", rdata_oe, 1'b0);
    rd = 1'b0;

    // ---------------- full load: 32 bytes, no ld_last ----------------
    for (int i = 0; i < 32; i++) load_byte(8'(i), 1'b0);
    @(negedge clk);
    check("full.ld_ready_low",  ld_ready, 1'b0);
    check("full.cpu_rst_still", cpu_rst,  1'b1);
    @(negedge clk);
    check("full.cpu_rst_rel",   cpu_rst,  1'b0);
    read_chk("full.m5",  5'd5,  8'h05);
    read_chk("full.m0",  5'd0,  8'h00);
    read_chk("full.m31", 5'd31, 8'h1F);

    // ---------------- IO write ----------------
    cpu_write(5'd31, 8'h5A);
    check("io.out",     io_out,    8'h5A);
    check("io.strobe",  io_strobe, 1'b1);
    @(posedge clk); #1;
    check("io.strobe_1cyc", io_strobe, 1'b0);
    read_chk("io.rd31", 5'd31, 8'h5A);

    // back-to-back IO writes
    @(negedge clk);
    wr = 1'b1; addr = 5'd31; wdata = 8'h11;
    @(posedge clk); #1;
    check("b2b.out1",    io_out,    8'h11);
    check("b2b.strobe1", io_strobe, 1'b1);
    @(negedge clk);
    wdata = 8'h22;
    @(posedge clk); #1;
    wr = 1'b0;
    check("b2b.out2",    io_out,    8'h22);
    check("b2b.strobe2", io_strobe, 1'b1);
    @(posedge clk); #1;
    check("b2b.strobe_end", io_strobe, 1'b0);

    // non-IO write: no strobe, io_out unchanged
    cpu_write(5'd3, 8'h44);
    check("nio.strobe", io_strobe, 1'b0);
    check("nio.out",    io_out,    8'h22);
    read_chk("nio.m3", 5'd3, 8'h44);

    // ---------------- conflict rd & wr ----------------
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 5'd7; wdata = 8'h33;
    #1;
    check("conf.oe", rdata_oe, 1'b0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    read_chk("conf.m7", 5'd7, 8'h33);
`ifdef RESP_ERR_CHECK_EN
    check("conf.bus_err", bus_err, 1'b1);
    @(posedge clk); #1;
    check("conf.bus_err_sticky", bus_err, 1'b1);
`endif

    // ld_valid ignored in RUN
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'h99;
    #1;
    check("run.ld_ready", ld_ready, 1'b0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    read_chk("run.m0_kept", 5'd0, 8'h00);

    // ---------------- short load ----------------
    pulse_rst();
    #1;
    check("short.cpu_rst", cpu_rst, 1'b1);
`ifdef RESP_ERR_CHECK_EN
    check("short.bus_err_clr", bus_err, 1'b0);
`endif
    load_byte(8'hA1, 1'b0);
    load_byte(8'hB2, 1'b0);
    load_byte(8'hC3, 1'b1);
    @(negedge clk);
    check("short.ld_ready", ld_ready, 1'b0);
    @(negedge clk);
    check("short.cpu_rst_rel", cpu_rst, 1'b0);
    load_byte(8'h77, 1'b0);          // must not land in mem[3]
    read_chk("short.m0", 5'd0, 8'hA1);
    read_chk("short.m1", 5'd1, 8'hB2);
    read_chk("short.m2", 5'd2, 8'hC3);
    read_chk("short.m3", 5'd3, 8'h44);

    // ---------------- reset mid-load ----------------
    pulse_rst();
    for (int i = 0; i < 10; i++) load_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid.cpu_rst_in_rst", cpu_rst, 1'b1);
    #1 rst = 1'b0;
    load_byte(8'hEE, 1'b0);
    check("mid.cpu_rst_reload", cpu_rst, 1'b1);
    load_byte(8'hFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mid.cpu_rst_rel", cpu_rst, 1'b0);
    read_chk("mid.m0", 5'd0, 8'hEE);
    read_chk("mid.m1", 5'd1, 8'hFF);
    for (int i = 2; i < 10; i++) read_chk("mid.mk", 5'(i), 8'h10 + 8'(i));
    read_chk("mid.m10", 5'd10, 8'h0A);

    // ---------------- reset in RUN ----------------
    cpu_write(5'd31, 8'hC7);
    check("rrun.io_pre", io_out, 8'hC7);
    @(negedge clk);
    rd = 1'b1; addr = 5'd4;
    #2 rst = 1'b1;
    #1;
    check("rrun.cpu_rst",  cpu_rst,  1'b1);
    check("rrun.io_out",   io_out,   8'h00);
    check("rrun.rdata_oe", rdata_oe, 1'b0);
    #1 rst = 1'b0;
    rd = 1'b0;
    #1;
    check("rrun.ld_ready", ld_ready, 1'b1);
    @(posedge clk); #1;
    check("rrun.cpu_rst_hold", cpu_rst, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_responder
